// File: rtl/reservation_station_pkg.sv
// Shared types for the unified reservation station.
// Width macros fall back to local defaults when the core-wide defines are absent.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package reservation_station_pkg;
  localparam int REG_VAL_W    = `REG_VAL_WIDTH;
  localparam int PHY_REG_W    = `PHYSICAL_REG_NUM_WIDTH;
  localparam int ADDR_W       = `INST_ADDR_WIDTH;
  localparam int RS_DEPTH_DEF = 8;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
  } alu_op_t;

  // Decoded control bundle as produced by the decode stage.
  typedef struct packed {
    alu_op_t aluOp;
    logic    useImm;
    logic    isBranch;
    logic    memRead;
    logic    memWrite;
  } control_t;

  typedef struct packed {
    logic                 valid;
    logic                 rdy1;
    logic                 rdy2;
    logic [PHY_REG_W-1:0] tag1;
    logic [PHY_REG_W-1:0] tag2;
    logic [REG_VAL_W-1:0] val1;
    logic [REG_VAL_W-1:0] val2;
    logic [PHY_REG_W-1:0] dstTag;
    control_t             control;
    logic [ADDR_W-1:0]    pc;
    logic [REG_VAL_W-1:0] imm;
  } rs_entry_t;

  // Only what execute needs; tags and ready bits stay behind in the entry.
  typedef struct packed {
    logic [REG_VAL_W-1:0] val1;
    logic [REG_VAL_W-1:0] val2;
    logic [PHY_REG_W-1:0] dstTag;
    control_t             control;
    logic [ADDR_W-1:0]    pc;
    logic [REG_VAL_W-1:0] imm;
  } issue_payload_t;
endpackage

// File: rtl/reservation_station_if.sv
// Dispatch / CDB / issue bundle of the reservation station.
// RS_PERF_COUNTERS_EN adds the full_stall_cycles and issued_count outputs.
interface reservation_station_if #(
  parameter int RS_DEPTH = reservation_station_pkg::RS_DEPTH_DEF
);
  import reservation_station_pkg::*;

  logic                 flush;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [REG_VAL_W-1:0] disp_src_val1;
  logic [REG_VAL_W-1:0] disp_src_val2;
  logic                 disp_src_rdy1;
  logic                 disp_src_rdy2;
  logic [PHY_REG_W-1:0] disp_src_tag1;
  logic [PHY_REG_W-1:0] disp_src_tag2;
  logic [PHY_REG_W-1:0] disp_dst_tag;
  control_t             disp_control;
  logic [ADDR_W-1:0]    disp_pc;
  logic [REG_VAL_W-1:0] disp_imm;
  logic                 cdb_valid;
  logic [PHY_REG_W-1:0] cdb_tag;
  logic [REG_VAL_W-1:0] cdb_val;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [REG_VAL_W-1:0] issue_src_val1;
  logic [REG_VAL_W-1:0] issue_src_val2;
  logic [PHY_REG_W-1:0] issue_dst_tag;
  control_t             issue_control;
  logic [ADDR_W-1:0]    issue_pc;
  logic [REG_VAL_W-1:0] issue_imm;
  logic [$clog2(RS_DEPTH):0] occupancy;
`ifdef RS_PERF_COUNTERS_EN
  logic [31:0]          full_stall_cycles;
  logic [31:0]          issued_count;
`endif

  modport master (
    output flush, disp_valid, disp_src_val1, disp_src_val2, disp_src_rdy1, disp_src_rdy2,
           disp_src_tag1, disp_src_tag2, disp_dst_tag, disp_control, disp_pc, disp_imm,
           cdb_valid, cdb_tag, cdb_val, issue_ready,
    input  disp_ready, issue_valid, issue_src_val1, issue_src_val2, issue_dst_tag,
           issue_control, issue_pc, issue_imm, occupancy
`ifdef RS_PERF_COUNTERS_EN
           , full_stall_cycles, issued_count
`endif
  );

  modport slave (
    input  flush, disp_valid, disp_src_val1, disp_src_val2, disp_src_rdy1, disp_src_rdy2,
           disp_src_tag1, disp_src_tag2, disp_dst_tag, disp_control, disp_pc, disp_imm,
           cdb_valid, cdb_tag, cdb_val, issue_ready,
    output disp_ready, issue_valid, issue_src_val1, issue_src_val2, issue_dst_tag,
           issue_control, issue_pc, issue_imm, occupancy
`ifdef RS_PERF_COUNTERS_EN
           , full_stall_cycles, issued_count
`endif
  );
endinterface

// File: rtl/rs_age_matrix.sv
// Age matrix: older[r][c]=1 means entry r was allocated before entry c.
// Grants the single requesting entry that no other requester is older than.
module rs_age_matrix #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] allocOh,
  input  logic [N-1:0] freeOh,
  input  logic [N-1:0] reqVec,
  output logic [N-1:0] grantOh
);
  logic [N-1:0][N-1:0] older;

  // New entry becomes younger than everyone; a freed entry stops being older than anyone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older <= '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (r == c)          older[r][c] <= 1'b0;
          else if (allocOh[r]) older[r][c] <= 1'b0;
          else if (allocOh[c]) older[r][c] <= 1'b1;
          else if (freeOh[r])  older[r][c] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : gGrant
    logic [N-1:0] olderReq;
    for (genvar j = 0; j < N; j++) begin : gCol
      assign olderReq[j] = older[j][i] & reqVec[j];
    end
    assign grantOh[i] = reqVec[i] & ~(|olderReq);
  end
endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: holds renamed instructions until both operands
// are valid, captures CDB wakeups, issues the oldest ready entry.
// Optional macro RS_PERF_COUNTERS_EN adds saturating stall/issue counters.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF
) (
  input logic clk,
  input logic reset,
  reservation_station_if.slave rsIf
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int OCC_W = IDX_W + 1;

  rs_entry_t             entries [RS_DEPTH];
  rs_entry_t             newEntry;
  issue_payload_t        issueReg;
  logic                  issueValid;
  logic [OCC_W-1:0]      occ;
  logic [RS_DEPTH-1:0]   readyVec, allocOh, grantOh, freeOh;
  logic [IDX_W-1:0]      selIdx;
  logic                  allocFound, dispReady, dispFire, issueLoad, selFire;
  logic                  byp1, byp2;

  // Ready vector and lowest-index free slot.
  always_comb begin
    readyVec   = '0;
    allocOh    = '0;
    allocFound = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      readyVec[i] = entries[i].valid & entries[i].rdy1 & entries[i].rdy2;
      if (!entries[i].valid && !allocFound) begin
        allocOh[i] = 1'b1;
        allocFound = 1'b1;
      end
    end
  end

  // One-hot grant to index.
  always_comb begin
    selIdx = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (grantOh[i]) selIdx = IDX_W'(i);
  end

  assign dispReady = (occ != OCC_W'(RS_DEPTH));
  assign dispFire  = rsIf.disp_valid && dispReady && !rsIf.flush;
  assign issueLoad = !issueValid || rsIf.issue_ready;
  assign selFire   = issueLoad && (|readyVec) && !rsIf.flush;
  assign freeOh    = selFire ? grantOh : '0;

  // Dispatch-cycle bypass so a same-cycle broadcast is not lost.
  assign byp1 = rsIf.cdb_valid && !rsIf.disp_src_rdy1 && (rsIf.cdb_tag == rsIf.disp_src_tag1);
  assign byp2 = rsIf.cdb_valid && !rsIf.disp_src_rdy2 && (rsIf.cdb_tag == rsIf.disp_src_tag2);

  // Build the entry written on dispatch.
  always_comb begin
    newEntry         = '0;
    newEntry.valid   = 1'b1;
    newEntry.rdy1    = rsIf.disp_src_rdy1 | byp1;
    newEntry.rdy2    = rsIf.disp_src_rdy2 | byp2;
    newEntry.tag1    = rsIf.disp_src_tag1;
    newEntry.tag2    = rsIf.disp_src_tag2;
    newEntry.val1    = byp1 ? rsIf.cdb_val : rsIf.disp_src_val1;
    newEntry.val2    = byp2 ? rsIf.cdb_val : rsIf.disp_src_val2;
    newEntry.dstTag  = rsIf.disp_dst_tag;
    newEntry.control = rsIf.disp_control;
    newEntry.pc      = rsIf.disp_pc;
    newEntry.imm     = rsIf.disp_imm;
  end

  // Entry storage: free on issue, allocate on dispatch, capture CDB wakeups.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RS_DEPTH; i++) entries[i] <= '0;
    end else if (rsIf.flush) begin
      for (int i = 0; i < RS_DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (freeOh[i]) begin
          entries[i].valid <= 1'b0;
        end else if (dispFire && allocOh[i]) begin
          entries[i] <= newEntry;
        end else if (entries[i].valid && rsIf.cdb_valid) begin
          if (!entries[i].rdy1 && rsIf.cdb_tag == entries[i].tag1) begin
            entries[i].rdy1 <= 1'b1;
            entries[i].val1 <= rsIf.cdb_val;
          end
          if (!entries[i].rdy2 && rsIf.cdb_tag == entries[i].tag2) begin
            entries[i].rdy2 <= 1'b1;
            entries[i].val2 <= rsIf.cdb_val;
          end
        end
      end
    end
  end

  // Issue register: reloads when empty or accepted, otherwise holds stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issueValid <= 1'b0;
      issueReg   <= '0;
    end else if (rsIf.flush) begin
      issueValid <= 1'b0;
    end else if (issueLoad) begin
      issueValid <= |readyVec;
      if (|readyVec) begin
        issueReg.val1    <= entries[selIdx].val1;
        issueReg.val2    <= entries[selIdx].val2;
        issueReg.dstTag  <= entries[selIdx].dstTag;
        issueReg.control <= entries[selIdx].control;
        issueReg.pc      <= entries[selIdx].pc;
        issueReg.imm     <= entries[selIdx].imm;
      end
    end
  end

  // Occupancy tracks accepted dispatches minus freed entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           occ <= '0;
    else if (rsIf.flush) occ <= '0;
    else                 occ <= occ + {{(OCC_W-1){1'b0}}, dispFire} - {{(OCC_W-1){1'b0}}, selFire};
  end

  rs_age_matrix #(.N(RS_DEPTH)) uAge (
    .clk     (clk),
    .rst     (reset),
    .allocOh (dispFire ? allocOh : '0),
    .freeOh  (freeOh),
    .reqVec  (readyVec),
    .grantOh (grantOh)
  );

  assign rsIf.disp_ready     = dispReady;
  assign rsIf.occupancy      = occ;
  assign rsIf.issue_valid    = issueValid;
  assign rsIf.issue_src_val1 = issueReg.val1;
  assign rsIf.issue_src_val2 = issueReg.val2;
  assign rsIf.issue_dst_tag  = issueReg.dstTag;
  assign rsIf.issue_control  = issueReg.control;
  assign rsIf.issue_pc       = issueReg.pc;
  assign rsIf.issue_imm      = issueReg.imm;

`ifdef RS_PERF_COUNTERS_EN
  logic [31:0] fullStallCnt, issuedCnt;

  // Saturating perf counters; flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fullStallCnt <= '0;
      issuedCnt    <= '0;
    end else begin
      if (rsIf.disp_valid && !dispReady && fullStallCnt != '1) fullStallCnt <= fullStallCnt + 32'd1;
      if (selFire && issuedCnt != '1) issuedCnt <= issuedCnt + 32'd1;
    end
  end

  assign rsIf.full_stall_cycles = fullStallCnt;
  assign rsIf.issued_count      = issuedCnt;
`endif
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with an issue scoreboard.
module tb_reservation_station;
  import reservation_station_pkg::*;

  typedef struct packed {
    logic [REG_VAL_W-1:0] v1;
    logic [REG_VAL_W-1:0] v2;
    logic [PHY_REG_W-1:0] dst;
    logic [REG_VAL_W-1:0] imm;
    logic [ADDR_W-1:0]    pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  reservation_station_if #(.RS_DEPTH(8)) ifc ();

  reservation_station #(.RS_DEPTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .rsIf (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [REG_VAL_W-1:0] immOf(input logic [PHY_REG_W-1:0] d);
    return REG_VAL_W'(d) + 'h100;
  endfunction

  function automatic logic [ADDR_W-1:0] pcOf(input logic [PHY_REG_W-1:0] d);
    return ADDR_W'(d) << 2;
  endfunction

  task automatic drive(input logic [REG_VAL_W-1:0] v1, input logic r1, input logic [PHY_REG_W-1:0] t1,
                       input logic [REG_VAL_W-1:0] v2, input logic r2, input logic [PHY_REG_W-1:0] t2,
                       input logic [PHY_REG_W-1:0] dst);
    ifc.disp_valid    = 1'b1;
    ifc.disp_src_val1 = v1;
    ifc.disp_src_rdy1 = r1;
    ifc.disp_src_tag1 = t1;
    ifc.disp_src_val2 = v2;
    ifc.disp_src_rdy2 = r2;
    ifc.disp_src_tag2 = t2;
    ifc.disp_dst_tag  = dst;
    ifc.disp_imm      = immOf(dst);
    ifc.disp_pc       = pcOf(dst);
    ifc.disp_control  = '{aluOp: ALU_ADD, useImm: 1'b0, isBranch: 1'b0, memRead: 1'b0, memWrite: 1'b0};
  endtask

  task automatic expect_issue(input logic [REG_VAL_W-1:0] v1, input logic [REG_VAL_W-1:0] v2,
                              input logic [PHY_REG_W-1:0] dst);
    sb.push_back('{v1: v1, v2: v2, dst: dst, imm: immOf(dst), pc: pcOf(dst)});
  endtask

  task automatic cdb(input logic [PHY_REG_W-1:0] tag, input logic [REG_VAL_W-1:0] val);
    ifc.cdb_valid = 1'b1;
    ifc.cdb_tag   = tag;
    ifc.cdb_val   = val;
  endtask

  // Scoreboard: every accepted issue handshake must match the next expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (ifc.issue_valid && ifc.issue_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL issue_unexpected: observed dst %0h expected no issue", ifc.issue_dst_tag);
      end else begin
        e = sb.pop_front();
        chk("sb_val1", ifc.issue_src_val1, e.v1);
        chk("sb_val2", ifc.issue_src_val2, e.v2);
        chk("sb_dst",  ifc.issue_dst_tag,  e.dst);
        chk("sb_imm",  ifc.issue_imm,      e.imm);
        chk("sb_pc",   ifc.issue_pc,       e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ifc.flush = 1'b0;
    ifc.disp_valid = 1'b0;
    ifc.disp_src_val1 = '0; ifc.disp_src_val2 = '0;
    ifc.disp_src_rdy1 = 1'b0; ifc.disp_src_rdy2 = 1'b0;
    ifc.disp_src_tag1 = '0; ifc.disp_src_tag2 = '0;
    ifc.disp_dst_tag = '0; ifc.disp_control = '0;
    ifc.disp_pc = '0; ifc.disp_imm = '0;
    ifc.cdb_valid = 1'b0; ifc.cdb_tag = '0; ifc.cdb_val = '0;
    ifc.issue_ready = 1'b1;

    // Reset state
    #8;
    chk("rst_occ", ifc.occupancy, 0);
    chk("rst_issue_valid", ifc.issue_valid, 0);
    chk("rst_disp_ready", ifc.disp_ready, 1);
    chk("rst_issue_val1", ifc.issue_src_val1, 0);
    #4 reset = 1'b0;
    step();

    // Ready operands: issue the cycle after acceptance
    drive(5, 1, 0, 7, 1, 0, 12);
    expect_issue(5, 7, 12);
    step();
    ifc.disp_valid = 1'b0;
    chk("t1_occ_after_disp", ifc.occupancy, 1);
    chk("t1_no_issue_yet", ifc.issue_valid, 0);
    step();
    chk("t1_issue_valid", ifc.issue_valid, 1);
    chk("t1_occ_after_issue", ifc.occupancy, 0);
    step();

    // Late operand via CDB wakeup
    drive(0, 0, 20, 2, 1, 0, 13);
    expect_issue('hAB, 2, 13);
    step();
    ifc.disp_valid = 1'b0;
    step();
    step();
    cdb(20, 'hAB);
    step();
    ifc.cdb_valid = 1'b0;
    chk("t2_not_before_wake", ifc.issue_valid, 0);
    step();
    chk("t2_issue_valid", ifc.issue_valid, 1);
    chk("t2_val1", ifc.issue_src_val1, 'hAB);
    step();

    // Dispatch-cycle CDB bypass
    drive(4, 1, 0, 0, 0, 9, 14);
    cdb(9, 3);
    expect_issue(4, 3, 14);
    step();
    ifc.disp_valid = 1'b0;
    ifc.cdb_valid = 1'b0;
    step();
    chk("t3_issue_valid", ifc.issue_valid, 1);
    chk("t3_val2_bypass", ifc.issue_src_val2, 3);
    step();

    // Build an order where slot 3 is older than slot 1
    drive(0, 0, 40, 1, 1, 0, 20);       step();  // A -> slot 0
    drive(0, 0, 60, 'h0B, 1, 0, 21);    step();  // B -> slot 1
    drive(0, 0, 41, 1, 1, 0, 22);       step();  // C -> slot 2
    drive(0, 0, 50, 'h33, 1, 0, 23);    step();  // D -> slot 3
    ifc.disp_valid = 1'b0;
    expect_issue('h66, 'h0B, 21);
    cdb(60, 'h66);
    step();
    ifc.cdb_valid = 1'b0;
    step();                                       // B issues, slot 1 freed
    drive(0, 0, 50, 'h44, 1, 0, 24);    step();  // E -> slot 1, younger than D
    ifc.issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, PHY_REG_W'(42 + i), 1, 1, 0, PHY_REG_W'(25 + i));
      step();
    end
    chk("full_disp_ready", ifc.disp_ready, 0);
    chk("full_occ", ifc.occupancy, 8);
    drive(9, 1, 0, 9, 1, 0, 29);                 // rejected 9th dispatch
    step();
    ifc.disp_valid = 1'b0;
    chk("full_reject_occ", ifc.occupancy, 8);
    chk("full_reject_no_issue", ifc.issue_valid, 0);
    expect_issue('h55, 'h33, 23);
    expect_issue('h55, 'h44, 24);
    cdb(50, 'h55);
    step();
    ifc.cdb_valid = 1'b0;
    step();
    chk("age_issue_valid", ifc.issue_valid, 1);
    chk("age_oldest_first", ifc.issue_dst_tag, 23);
    chk("age_occ", ifc.occupancy, 7);

    // Stall: payload and occupancy hold
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_valid", ifc.issue_valid, 1);
      chk("hold_dst", ifc.issue_dst_tag, 23);
      chk("hold_val1", ifc.issue_src_val1, 'h55);
      chk("hold_occ", ifc.occupancy, 7);
    end
    ifc.issue_ready = 1'b1;
    step();
    ifc.issue_ready = 1'b0;
    chk("age_second_dst", ifc.issue_dst_tag, 24);
    chk("age_second_occ", ifc.occupancy, 6);

    // Flush with a concurrent dispatch that must be dropped
    ifc.flush = 1'b1;
    drive(1, 1, 0, 1, 1, 0, 31);
    step();
    ifc.flush = 1'b0;
    ifc.disp_valid = 1'b0;
    sb.delete();
    chk("flush_occ", ifc.occupancy, 0);
    chk("flush_issue_valid", ifc.issue_valid, 0);
    chk("flush_disp_ready", ifc.disp_ready, 1);
    step();
    chk("flush_drop_occ", ifc.occupancy, 0);
    chk("flush_drop_issue", ifc.issue_valid, 0);

    // Asynchronous reset with five entries and a held issue
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, PHY_REG_W'(33 + i), 0, 1, 0, PHY_REG_W'(40 + i));
      step();
    end
    drive('h11, 1, 0, 'h22, 1, 0, 45);
    step();
    ifc.disp_valid = 1'b0;
    step();
    chk("pre_rst_occ", ifc.occupancy, 5);
    chk("pre_rst_issue_valid", ifc.issue_valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_occ", ifc.occupancy, 0);
    chk("async_rst_issue_valid", ifc.issue_valid, 0);
    chk("async_rst_val1", ifc.issue_src_val1, 0);
    chk("async_rst_dst", ifc.issue_dst_tag, 0);
    chk("async_rst_disp_ready", ifc.disp_ready, 1);
    #2 reset = 1'b0;
    step();
    chk("post_rst_disp_ready", ifc.disp_ready, 1);
    chk("post_rst_occ", ifc.occupancy, 0);

    // Normal operation after reset
    ifc.issue_ready = 1'b1;
    drive('h77, 1, 0, 'h88, 1, 0, 50);
    expect_issue('h77, 'h88, 50);
    step();
    ifc.disp_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    step();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Unified reservation station directly downstream of PHY_REGFILE_WRAPPER.
- Accepts one renamed, operand-read instruction per cycle and holds it until both source operands are valid.
- Captures late operands from the common data bus (CDB).
- Each cycle, issues the oldest ready entry to the execute stage through a registered valid/ready issue port.

Parameters:
- RS_DEPTH, 8, number of entries (power of two, 2..16).
- REG_VAL_WIDTH, `REG_VAL_WIDTH, operand/immediate width.
- PHY_REG_W, `PHYSICAL_REG_NUM_WIDTH, physical register tag width.
- ADDR_W, `INST_ADDR_WIDTH, PC width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all entries and the issue register.
- disp_valid  in  1  dispatch request from the regfile stage.
- disp_ready  out  1  RS not full; dispatch accepted when disp_valid && disp_ready.
- disp_src_val1 / disp_src_val2  in  REG_VAL_WIDTH  operand values read from the regfile.
- disp_src_rdy1 / disp_src_rdy2  in  1  operand value already valid.
- disp_src_tag1 / disp_src_tag2  in  PHY_REG_W  source physical register tags.
- disp_dst_tag  in  PHY_REG_W  destination physical register.
- disp_control  in  control_t  decoded control bundle.
- disp_pc  in  ADDR_W  instruction PC.
- disp_imm  in  REG_VAL_WIDTH  generated immediate.
- cdb_valid  in  1  writeback broadcast this cycle.
- cdb_tag  in  PHY_REG_W  broadcast tag.
- cdb_val  in  REG_VAL_WIDTH  broadcast value.
- issue_valid  out  1  issue register holds an instruction.
- issue_ready  in  1  execute unit accepts.
- issue_src_val1 / issue_src_val2, issue_dst_tag, issue_control, issue_pc, issue_imm  out  issued payload (same widths as the dispatch fields).
- occupancy  out  $clog2(RS_DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async): all entry valid bits, issue_valid, occupancy and all issue payload outputs = 0.
- Dispatch writes the lowest-index free entry. disp_ready = (occupancy != RS_DEPTH), combinational from registered state.
- Wakeup: for every valid entry with rdyN=0 and cdb_valid && cdb_tag==tagN, capture cdb_val and set rdyN at the next edge.
- Dispatch-cycle CDB bypass: if the CDB matches a dispatching source with disp_src_rdyN=0, the entry is written with the CDB value and rdy=1 (no lost wakeup).
- Select: among entries with rdy1 && rdy2, pick the oldest by the age matrix.
- The issue register loads when (!issue_valid || issue_ready). The selected entry is freed in the same edge.
- While issue_valid && !issue_ready, the issue register holds stable and no entry is freed.
- Latency: operand-ready dispatch at edge N gives earliest issue_valid after edge N+1. CDB wakeup at edge N makes the entry selectable in cycle N+1.
- Full: a dispatch and an issue in the same cycle at full occupancy is not accepted (disp_ready reflects registered occupancy).
- occupancy = previous + accepted_dispatch − freed_entry (both may occur; net 0).
- flush: clears all valid bits and issue_valid next edge; same-cycle dispatch is dropped; flush has priority over everything except reset.
- Reset mid-operation discards all contents immediately.

Optional Feature:
- Macro: RS_PERF_COUNTERS_EN.
- When defined: adds 32-bit outputs full_stall_cycles (increments each cycle disp_valid && !disp_ready) and issued_count (increments per issue-register load). Both saturate at all-ones, reset to 0, and are not cleared by flush.
- When undefined: neither port nor logic exists.

Decomposition:
- Shared package (extended): rs_entry_t struct (valid, rdy1, rdy2, tag1, tag2, val1, val2, dst_tag, control_t, pc, imm) and RS_DEPTH default constant. control_t is reused unchanged.
- Sub-module rs_age_matrix:
  - RS_DEPTH×RS_DEPTH older-than bits.
  - Inputs: allocate one-hot, free one-hot, request vector.
  - Output: one-hot oldest-request grant.

Test Plan:
- Dispatch ADD with both rdy=1 (val1=5, val2=7, dst=12) into empty RS, issue_ready=1 -> issue_valid high in the cycle after acceptance with vals 5/7, dst 12; occupancy 1→0.
- Dispatch entry tag1=20 rdy1=0; two cycles later CDB tag=20 val=0xAB -> issue_valid the cycle after the broadcast with issue_src_val1=0xAB.
- Dispatch with tag2=9 rdy2=0 in the same cycle as CDB tag=9 val=3 -> entry issues next cycle with val2=3 (bypass).
- Fill 8 entries with rdy=0, issue_ready=0 -> disp_ready=0 and the 9th dispatch is rejected. Then wake entries 3 and 1 in the same cycle, where entry 3 was dispatched first -> entry 3 issues first.
- Hold issue_ready=0 for 4 cycles with issue_valid=1 -> payload is stable and occupancy unchanged. flush then gives occupancy=0 and issue_valid=0 next cycle.
- Assert reset asynchronously mid-clock with 5 entries valid -> outputs go 0 immediately, disp_ready=1 after release.
